// File: rtl/abc_scan_pkg.sv
// abc_scan_pkg: shared state encoding and constants for the 3-input truth-table scanner.
package abc_scan_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_e;
    localparam logic [2:0] LAST_IDX = 3'd7;
    localparam logic [7:0] EXP_F    = 8'hCE;
endpackage

// File: rtl/abc_truth_scanner.sv
// abc_truth_scanner: steps {a,b,c} through 000..111, samples f_in per code and checks the table.
module abc_truth_scanner
    import abc_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] expected_i,
    input  logic       f_in_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_out_o,
    output logic       pass_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       table_q, table_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            table_q <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        pass_d  = pass_q;
        if (abort_i) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_d = S_DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    table_d = 8'd0;
                    pass_d  = 1'b0;
                end
                S_DRIVE: begin
                    cnt_d = cnt_q + 1'b1;
                    // last cycle of the hold: capture, then advance or finish
                    if (cnt_q == CNT_LAST) begin
                        table_d[idx_q] = f_in_i;
                        cnt_d          = '0;
                        if (idx_q == LAST_IDX) state_d = S_DONE;
                        else idx_d = idx_q + 3'd1;
                    end
                end
                S_DONE: begin
                    pass_d  = (table_q == expected_i);
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign {a_o, b_o, c_o} = idx_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign table_out_o     = table_q;
    assign pass_o          = pass_q;
endmodule

// File: tb/tb_abc_truth_scanner.sv
// tb_abc_truth_scanner: directed scans on DWELL=4 and DWELL=1 instances, scoreboarded done/table/pass.
module tb_abc_truth_scanner;
    localparam logic [7:0] F_TBL = 8'hCE;

    typedef struct {
        logic [7:0] tbl;
        logic       p;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q4[$];
    exp_t q1[$];

    logic       start4 = 0, abort4 = 0, start1 = 0, abort1 = 0;
    logic [7:0] expected4 = F_TBL, expected1 = F_TBL;
    logic       a4, b4, c4, busy4, done4, pass4, f4;
    logic       a1, b1, c1, busy1, done1, pass1, f1;
    logic [7:0] tbl4, tbl1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f4 = F_TBL[{a4, b4, c4}];
    assign f1 = F_TBL[{a1, b1, c1}];

    abc_truth_scanner #(.DWELL(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .abort_i(abort4),
        .expected_i(expected4), .f_in_i(f4), .a_o(a4), .b_o(b4), .c_o(c4),
        .busy_o(busy4), .done_o(done4), .table_out_o(tbl4), .pass_o(pass4)
    );

    abc_truth_scanner #(.DWELL(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
        .expected_i(expected1), .f_in_i(f1), .a_o(a1), .b_o(b1), .c_o(c1),
        .busy_o(busy1), .done_o(done1), .table_out_o(tbl1), .pass_o(pass1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                e = q4.pop_front();
                chk("done_cyc4", cyc, e.cyc);
                chk("table4", tbl4, e.tbl);
                chk("abc_done4", {a4, b4, c4}, 3'b111);
                chk("busy_done4", busy4, 1);
                @(negedge clk);
                chk("pass4", pass4, e.p);
                chk("done_pulse4", done4, 0);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("done_cyc1", cyc, e.cyc);
                chk("table1", tbl1, e.tbl);
                @(negedge clk);
                chk("pass1", pass1, e.p);
            end
        end
    end

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain4_timeout", q4.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] expv, input logic p);
        expected4 = expv;
        q4.push_back('{tbl: F_TBL, p: p, cyc: cyc + 33});
        start4 = 1;
        @(negedge clk);
        start4 = 0;
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_abc", {a4, b4, c4}, 0);
        chk("rst_done", done4, 0);
        chk("rst_table", tbl4, 0);
        chk("rst_pass", pass4, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("idle_abc", {a4, b4, c4}, 0);
        chk("idle_busy", busy4, 0);

        // golden scan
        scan4(8'hCE, 1);
        chk("drive_busy", busy4, 1);
        drain4();
        // mismatch against expected 8'hCF
        scan4(8'hCF, 0);
        drain4();
        // second start while busy must be ignored
        scan4(8'hCE, 1);
        repeat (8) @(negedge clk);
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        drain4();

        // abort at idx 3
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        for (int i = 0; i < 50 && {a4, b4, c4} != 3'd3; i++) @(negedge clk);
        chk("reach_idx3", {a4, b4, c4}, 3);
        abort4 = 1;
        @(negedge clk);
        abort4 = 0;
        chk("abort_busy", busy4, 0);
        chk("abort_abc", {a4, b4, c4}, 0);
        chk("abort_pass", pass4, 0);
        chk("abort_tbl_lo", tbl4[2:0], 3'b110);
        // abort wins over start in IDLE
        start4 = 1;
        abort4 = 1;
        @(negedge clk);
        start4 = 0;
        abort4 = 0;
        chk("abort_start_busy", busy4, 0);
        repeat (40) @(negedge clk);

        // DWELL=1 back-to-back with start held
        expected1 = 8'hCE;
        for (int k = 0; k < 3; k++) q1.push_back('{tbl: F_TBL, p: 1'b1, cyc: cyc + 9 + 10 * k});
        start1 = 1;
        repeat (29) @(negedge clk);
        start1 = 0;
        repeat (20) @(negedge clk);
        chk("q1_empty", q1.size(), 0);
        chk("dwell1_idle", busy1, 0);

        // reset mid-scan
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        repeat (12) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_busy", busy4, 0);
        chk("midrst_abc", {a4, b4, c4}, 0);
        chk("midrst_table", tbl4, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        chk("q4_empty", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
